// File: rtl/seqdetect_param_if.sv
// Bus bundle for seqdetect_param: serial input, pattern config, match status.
// The testbench drives the master side; the detector uses the slave side.
interface seqdetect_param_if #(
   parameter int unsigned PAT_W = 4,
   parameter int unsigned CNT_W = 8
);
   logic             inp_valid;
   logic             inp_bit;
   logic             cfg_load;
   logic [PAT_W-1:0] cfg_pattern;
   logic             overlap_en;
   logic             cnt_clr;
   logic             seq_seen;
   logic [CNT_W-1:0] match_count;

   modport master (
      output inp_valid, inp_bit, cfg_load, cfg_pattern, overlap_en, cnt_clr,
      input  seq_seen, match_count
   );

   modport slave (
      input  inp_valid, inp_bit, cfg_load, cfg_pattern, overlap_en, cnt_clr,
      output seq_seen, match_count
   );
endinterface

// File: rtl/seqdetect_param.sv
// Serial sequence detector with a runtime-loadable PAT_W-bit pattern and
// overlapping/non-overlapping modes. SEQDETECT_COUNT_EN adds a saturating match counter.
module seqdetect_param #(
   parameter int unsigned     PAT_W    = 4,
   parameter logic [PAT_W-1:0] PAT_INIT = PAT_W'(4'b1011),
   parameter int unsigned     CNT_W    = 8
) (
   input logic              clk,
   input logic              reset_n,
   seqdetect_param_if.slave bus
);
   localparam int unsigned FILL_W = $clog2(PAT_W + 1);
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
   localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PAT_W - 1);

   typedef enum logic {FILL, ARMED} state_e;

   state_e            state_q, state_d;
   logic [PAT_W-1:0]  pat_q, pat_d;
   logic [PAT_W-1:0]  hist_q, hist_d;
   logic [FILL_W-1:0] fill_q, fill_d;
   logic              seen_q, seen_d;
   logic [PAT_W-1:0]  shifted;
   logic              match;

   assign shifted = {hist_q[PAT_W-2:0], bus.inp_bit};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= FILL;
         pat_q   <= PAT_INIT;
         hist_q  <= '0;
         fill_q  <= '0;
         seen_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pat_q   <= pat_d;
         hist_q  <= hist_d;
         fill_q  <= fill_d;
         seen_q  <= seen_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pat_d   = pat_q;
      hist_d  = hist_q;
      fill_d  = fill_q;
      seen_d  = 1'b0;
      match   = 1'b0;
      if (bus.cfg_load) begin
         pat_d   = bus.cfg_pattern;
         hist_d  = '0;
         fill_d  = '0;
         state_d = FILL;
      end else if (bus.inp_valid) begin
         // ARMED is exactly fill==PAT_W; the last FILL bit may already complete a match
         match  = ((state_q == ARMED) || (fill_q == FILL_LAST)) && (shifted == pat_q);
         hist_d = shifted;
         unique case (state_q)
            FILL: begin
               fill_d = fill_q + FILL_W'(1);
               if (fill_q == FILL_LAST) state_d = ARMED;
            end
            ARMED: fill_d = FILL_FULL;
            default: state_d = FILL;
         endcase
         if (match) begin
            seen_d = 1'b1;
            if (bus.overlap_en) begin
               fill_d  = FILL_FULL;
               state_d = ARMED;
            end else begin
               hist_d  = '0;
               fill_d  = '0;
               state_d = FILL;
            end
         end
      end
   end

   assign bus.seq_seen = seen_q;

`ifdef SEQDETECT_COUNT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) cnt_q <= '0;
      else          cnt_q <= cnt_d;
   end

   // Clear takes priority over a coincident match
   always_comb begin
      cnt_d = cnt_q;
      if (bus.cnt_clr)                 cnt_d = '0;
      else if (match && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
   end

   assign bus.match_count = cnt_q;
`else
   logic unused_cnt;
   assign unused_cnt      = bus.cnt_clr;
   assign bus.match_count = '0;
`endif

endmodule

// File: tb/tb_seqdetect_param.sv
// Self-checking bench for seqdetect_param: directed test-plan cases plus a
// randomized run against a queue-based reference model.
module tb_seqdetect_param;
   localparam int unsigned PAT_W = 4;
   localparam int unsigned CNT_W = 2;
   localparam logic [PAT_W-1:0] PAT_RST = 4'b1011;
`ifdef SEQDETECT_COUNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic clk;
   logic reset_n;

   seqdetect_param_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) bus ();

   seqdetect_param #(.PAT_W(PAT_W), .PAT_INIT(PAT_RST), .CNT_W(CNT_W)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int pulses   = 0;

   // Reference model: the accepted bits since the last restart
   bit               m_bits[$];
   logic [PAT_W-1:0] m_pat;
   int unsigned      m_cnt;
   logic             exp_seen;
   logic             ovl;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_bits.delete();
      m_pat    = PAT_RST;
      m_cnt    = 0;
      exp_seen = 1'b0;
   endtask

   task automatic model_step(input logic v, input logic b, input logic ld,
                             input logic [PAT_W-1:0] pat, input logic ov, input logic clr);
      logic [PAT_W-1:0] tail;
      bit hit;
      hit = 1'b0;
      if (ld) begin
         m_pat = pat;
         m_bits.delete();
      end else if (v) begin
         m_bits.push_back(b);
         if (m_bits.size() > PAT_W) void'(m_bits.pop_front());
         if (m_bits.size() == PAT_W) begin
            tail = '0;
            foreach (m_bits[i]) tail = {tail[PAT_W-2:0], m_bits[i]};
            hit = (tail == m_pat);
         end
         if (hit && !ov) m_bits.delete();
      end
      exp_seen = hit;
      if (clr) m_cnt = 0;
      else if (hit && m_cnt < (2 ** CNT_W) - 1) m_cnt++;
   endtask

   task automatic cyc(input logic v, input logic b, input logic ld,
                      input logic [PAT_W-1:0] pat, input logic ov, input logic clr);
      bus.inp_valid   = v;
      bus.inp_bit     = b;
      bus.cfg_load    = ld;
      bus.cfg_pattern = pat;
      bus.overlap_en  = ov;
      bus.cnt_clr     = clr;
      @(posedge clk);
      #1;
      model_step(v, b, ld, pat, ov, clr);
      check_eq("seq_seen", 32'(bus.seq_seen), 32'(exp_seen));
      check_eq("match_count", 32'(bus.match_count), CNT_EN ? m_cnt : 32'd0);
      pulses += int'(bus.seq_seen);
   endtask

   task automatic send(input logic b);
      cyc(1'b1, b, 1'b0, '0, ovl, 1'b0);
   endtask

   task automatic idle();
      cyc(1'b0, 1'b0, 1'b0, '0, ovl, 1'b0);
   endtask

   task automatic load(input logic [PAT_W-1:0] p);
      cyc(1'b0, 1'b0, 1'b1, p, ovl, 1'b0);
   endtask

   task automatic send_word(input logic [PAT_W-1:0] w);
      for (int i = PAT_W - 1; i >= 0; i--) send(w[i]);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      #1;
      model_reset();
      check_eq("rst_seen", 32'(bus.seq_seen), 32'd0);
      check_eq("rst_count", 32'(bus.match_count), 32'd0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   initial begin
      logic [6:0] s7;
      reset_n         = 1'b0;
      bus.inp_valid   = 1'b0;
      bus.inp_bit     = 1'b0;
      bus.cfg_load    = 1'b0;
      bus.cfg_pattern = '0;
      bus.overlap_en  = 1'b0;
      bus.cnt_clr     = 1'b0;
      ovl             = 1'b0;
      model_reset();
      #2;
      check_eq("por_seen", 32'(bus.seq_seen), 32'd0);
      check_eq("por_count", 32'(bus.match_count), 32'd0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;

      // Reset pattern, non-overlap: 1,0,1,1 -> one pulse
      pulses = 0;
      send_word(4'b1011);
      idle();
      check_eq("t1_pulses", pulses, 1);
      check_eq("t1_count", 32'(bus.match_count), CNT_EN ? 32'd1 : 32'd0);

      s7 = 7'b1011011;
      ovl = 1'b1; load(4'b1011); pulses = 0;
      for (int i = 6; i >= 0; i--) send(s7[i]);
      idle();
      check_eq("t2_ovl_pulses", pulses, 2);
      ovl = 1'b0; load(4'b1011); pulses = 0;
      for (int i = 6; i >= 0; i--) send(s7[i]);
      idle();
      check_eq("t2_novl_pulses", pulses, 1);

      // Pattern 1111 with overlap: consecutive pulses; counter saturates at 3
      cyc(1'b0, 1'b0, 1'b0, '0, ovl, 1'b1);
      ovl = 1'b1; load(4'b1111); pulses = 0;
      for (int i = 0; i < 6; i++) send(1'b1);
      idle();
      check_eq("t3_pulses", pulses, 3);
      check_eq("t3_count", 32'(bus.match_count), CNT_EN ? 32'd3 : 32'd0);

      // Valid gaps between bits 2 and 3
      ovl = 1'b0; load(4'b1011); pulses = 0;
      send(1'b1); send(1'b0); idle(); idle(); idle(); send(1'b1); send(1'b1);
      idle();
      check_eq("t4_gap_pulses", pulses, 1);
      load(4'b1011); pulses = 0;
      send(1'b1); send(1'b0);
      cyc(1'b1, 1'b1, 1'b1, 4'b1011, ovl, 1'b0);
      send(1'b1); idle();
      check_eq("t4_load_pulses", pulses, 0);

      // Reset mid-stream
      load(4'b1011); pulses = 0;
      send(1'b1); send(1'b0); send(1'b1);
      do_reset();
      send(1'b1); idle();
      check_eq("t5_after_rst", pulses, 0);
      send(1'b0); send(1'b1); send(1'b1); idle();
      check_eq("t5_resume", pulses, 1);

      // Saturation then clear coincident with a match
      cyc(1'b0, 1'b0, 1'b0, '0, ovl, 1'b1);
      for (int k = 0; k < 5; k++) send_word(4'b1011);
      check_eq("t6_sat", 32'(bus.match_count), CNT_EN ? 32'd3 : 32'd0);
      send(1'b1); send(1'b0); send(1'b1);
      cyc(1'b1, 1'b1, 1'b0, '0, ovl, 1'b1);
      check_eq("t6_clr_wins", 32'(bus.match_count), 32'd0);

      // Randomized run
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(199) == 0) begin
            do_reset();
         end else begin
            ovl = 1'($urandom_range(1));
            cyc(1'($urandom_range(9) < 7), 1'($urandom_range(1)),
                1'($urandom_range(49) == 0), PAT_W'($urandom),
                ovl, 1'($urandom_range(29) == 0));
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
